// File: rtl/hostaddr_streamer_pkg.sv
// Shared widths and FSM state type for the host address streamer.
package hostaddr_streamer_pkg;

  // System-wide field widths of the host address RAM entries.
  localparam int HOST_ADDR_WIDTH  = 4;
  localparam int VALUE_DATA_WIDTH = 72;
  localparam int VALUE_SIZE       = 8;

  // Read sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_LOAD   = 2'd2,
    ST_STREAM = 2'd3
  } state_e;

endpackage : hostaddr_streamer_pkg

// File: rtl/hostaddr_streamer_value_serializer.sv
// Loads one RAM entry value and emits it MSByte first, one byte per
// valid/ready beat, with a last marker and empty/over-length pulses.
module hostaddr_streamer_value_serializer #(
  parameter int DATA_W = 72,
  parameter int SIZE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] value_i,
  input  logic [SIZE_W-1:0] size_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic              empty,
  output logic              err_len,
  output logic              done_o
);

  localparam int NB = DATA_W / 8;
  localparam logic [SIZE_W-1:0] NB_SZ = SIZE_W'(NB);

  logic [DATA_W-1:0] sh_q, sh_d;
  logic [SIZE_W-1:0] cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              empty_q, empty_d;
  logic              err_len_q, err_len_d;
  logic              fire;

  assign fire      = valid_q && out_ready;
  assign out_valid = valid_q;
  assign out_byte  = sh_q[DATA_W-1 -: 8];
  assign out_last  = valid_q && (cnt_q == SIZE_W'(1));
  assign empty     = empty_q;
  assign err_len   = err_len_q;
  assign done_o    = fire && out_last;

  // Next-state: load has priority; otherwise shift one byte per handshake.
  always_comb begin
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    empty_d   = 1'b0;
    err_len_d = 1'b0;
    if (load_i) begin
      sh_d      = value_i;
      empty_d   = (size_i == '0);
      err_len_d = (size_i > NB_SZ);
      // Over-length entries are clamped to the bytes the value field holds.
      cnt_d     = (size_i > NB_SZ) ? NB_SZ : size_i;
      valid_d   = (size_i != '0);
    end else if (fire) begin
      sh_d  = sh_q << 8;
      cnt_d = cnt_q - SIZE_W'(1);
      if (cnt_q == SIZE_W'(1)) begin
        valid_d = 1'b0;
      end
    end
  end

  // Output stage registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q      <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      empty_q   <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      empty_q   <= empty_d;
      err_len_q <= err_len_d;
    end
  end

endmodule : hostaddr_streamer_value_serializer

// File: rtl/hostaddr_streamer.sv
// Host address streamer: accepts a host index, reads the entry through the
// RAM's registered-address port and streams the value bytes out.
module hostaddr_streamer
  import hostaddr_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = HOST_ADDR_WIDTH,
  parameter int DATA_W     = VALUE_DATA_WIDTH,
  parameter int SIZE_W     = VALUE_SIZE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_WIDTH-1:0]    req_host,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic [DATA_W+SIZE_W-1:0] mem_q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_byte,
  output logic                     out_last,
  output logic                     empty,
  output logic                     err_len
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  load;
  logic                  size_zero;
  logic                  stream_done;
  logic [DATA_W-1:0]     entry_value;
  logic [SIZE_W-1:0]     entry_size;

  assign entry_value = mem_q[DATA_W+SIZE_W-1:SIZE_W];
  assign entry_size  = mem_q[SIZE_W-1:0];
  assign size_zero   = (entry_size == '0);
  assign load        = (state_q == ST_LOAD);
  assign req_ready   = (state_q == ST_IDLE);
  assign mem_addr    = mem_addr_q;

  // Read sequencing: capture address, wait for the RAM, load, then stream.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          mem_addr_d = req_host;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = size_zero ? ST_IDLE : ST_STREAM;
      end
      ST_STREAM: begin
        if (stream_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and RAM address registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  hostaddr_streamer_value_serializer #(
    .DATA_W (DATA_W),
    .SIZE_W (SIZE_W)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .value_i   (entry_value),
    .size_i    (entry_size),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .empty     (empty),
    .err_len   (err_len),
    .done_o    (stream_done)
  );

endmodule : hostaddr_streamer

// File: tb/tb_hostaddr_streamer.sv
// Directed bench for hostaddr_streamer with a registered-address RAM model.
`define CHK(tag, o, e) chk(tag, 72'(o), 72'(e))

module tb_hostaddr_streamer;
  import hostaddr_streamer_pkg::*;

  localparam int AW = HOST_ADDR_WIDTH;
  localparam int DW = VALUE_DATA_WIDTH;
  localparam int SW = VALUE_SIZE;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_host;
  logic [AW-1:0] mem_addr;
  logic [DW+SW-1:0] mem_q;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_byte;
  logic          out_last;
  logic          empty;
  logic          err_len;

  logic [DW+SW-1:0] ram [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Registered-address RAM read port.
  always @(posedge clk) mem_q <= ram[mem_addr];

  hostaddr_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_host  (req_host),
    .mem_addr  (mem_addr),
    .mem_q     (mem_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .empty     (empty),
    .err_len   (err_len)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [AW-1:0] h);
    req_host  = h;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  pat;
    logic [23:0] got3;
    logic [71:0] got9;
    int hs, beats, errs, last_idx, n;
    logic prev_last;

    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    ram[0] = {16'h5859, 56'h0, 8'd2};
    ram[1] = {24'h414243, 48'h0, 8'd3};
    ram[2] = {72'h0, 8'd0};
    ram[3] = {72'h6f726465726d617463, 8'd14};

    rst_n = 1'b0; req_valid = 1'b0; req_host = '0; out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    `CHK("rst_out_valid", out_valid, 0);
    `CHK("rst_out_byte", out_byte, 0);
    `CHK("rst_out_last", out_last, 0);
    `CHK("rst_empty", empty, 0);
    `CHK("rst_err_len", err_len, 0);
    `CHK("rst_mem_addr", mem_addr, 0);
    `CHK("rst_req_ready", req_ready, 1);

    // Host 1, consumer always ready.
    out_ready = 1'b1;
    do_req(1);
    `CHK("h1_busy", req_ready, 0);
    `CHK("h1_mem_addr", mem_addr, 1);
    `CHK("h1_addr_novalid", out_valid, 0);
    tick();
    `CHK("h1_load_novalid", out_valid, 0);
    tick();
    `CHK("h1_b0_valid", out_valid, 1);
    `CHK("h1_b0", out_byte, 8'h41);
    `CHK("h1_b0_last", out_last, 0);
    tick();
    `CHK("h1_b1", out_byte, 8'h42);
    `CHK("h1_b1_last", out_last, 0);
    tick();
    `CHK("h1_b2", out_byte, 8'h43);
    `CHK("h1_b2_last", out_last, 1);
    tick();
    `CHK("h1_done_valid", out_valid, 0);
    `CHK("h1_done_ready", req_ready, 1);

    // Host 1 again with a stalling consumer: 1,0,0,1,1.
    pat = 5'b10011;
    hs = 0; got3 = '0;
    do_req(1);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      out_ready = pat[4-i];
      if (i == 1 || i == 2) `CHK("stall_hold_byte", out_byte, 8'h42);
      if (i == 1 || i == 2) `CHK("stall_hold_last", out_last, 0);
      if (out_valid && out_ready) begin
        got3 = {got3[15:0], out_byte};
        hs++;
        if (hs == 3) `CHK("stall_last", out_last, 1);
      end
      tick();
    end
    `CHK("stall_handshakes", hs, 3);
    `CHK("stall_order", got3, 24'h414243);
    `CHK("stall_done_valid", out_valid, 0);
    out_ready = 1'b1;

    // Host 2, zero size.
    do_req(2);
    tick();
    `CHK("h2_load_busy", req_ready, 0);
    tick();
    `CHK("h2_empty", empty, 1);
    `CHK("h2_ready_back", req_ready, 1);
    `CHK("h2_novalid", out_valid, 0);
    tick();
    `CHK("h2_empty_once", empty, 0);
    `CHK("h2_novalid2", out_valid, 0);

    // Host 3, size NB+5: clamp to NB bytes.
    do_req(3);
    tick();
    tick();
    `CHK("h3_err_len", err_len, 1);
    beats = 0; errs = 0; last_idx = -1; got9 = '0;
    for (int i = 0; i < 20 && out_valid; i++) begin
      if (err_len) errs++;
      if (out_last) last_idx = beats;
      got9 = {got9[63:0], out_byte};
      beats++;
      tick();
    end
    `CHK("h3_beats", beats, 9);
    `CHK("h3_err_pulses", errs, 1);
    `CHK("h3_last_idx", last_idx, 8);
    `CHK("h3_bytes", got9, 72'h6f726465726d617463);
    `CHK("h3_err_clear", err_len, 0);

    // Back-to-back: hosts 0 then 1 with req_valid held.
    req_host = 0; req_valid = 1'b1;
    `CHK("b2b_first_ready", req_ready, 1);
    tick();
    req_host = 1;
    n = 1; prev_last = 1'b0;
    while (!req_ready && n < 10) begin
      `CHK("b2b_addr_hold", mem_addr, 0);
      prev_last = out_valid && out_last;
      tick();
      n++;
    end
    `CHK("b2b_idle_cycle", n, 5);
    `CHK("b2b_prev_last", prev_last, 1);
    `CHK("b2b_addr_before_accept", mem_addr, 0);
    tick();
    req_valid = 1'b0;
    `CHK("b2b_addr_after_accept", mem_addr, 1);
    tick();
    tick();
    `CHK("b2b_second_b0", out_byte, 8'h41);
    `CHK("b2b_second_valid", out_valid, 1);
    repeat (3) tick();
    `CHK("b2b_second_done", req_ready, 1);

    // Reset during a stalled 3-byte stream.
    out_ready = 1'b0;
    do_req(1);
    tick();
    tick();
    `CHK("rs_stream_valid", out_valid, 1);
    rst_n = 1'b0;
    tick();
    `CHK("rs_valid_drop", out_valid, 0);
    `CHK("rs_byte_clear", out_byte, 0);
    rst_n = 1'b1;
    tick();
    `CHK("rs_idle_ready", req_ready, 1);
    `CHK("rs_idle_novalid", out_valid, 0);
    out_ready = 1'b1;
    do_req(0);
    tick();
    tick();
    `CHK("rs_restart_b0", out_byte, 8'h58);
    tick();
    `CHK("rs_restart_b1", out_byte, 8'h59);
    `CHK("rs_restart_last", out_last, 1);
    tick();
    `CHK("rs_restart_done", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_hostaddr_streamer
